// File: rtl/rv32i_core.sv
// ----------------------------------------------------------------------------
// rv32i_core
//
// Purpose:
//   Single-cycle RV32I integer core. Every rising clock edge retires exactly
//   one instruction. Instruction and data memories are external. The memory
//   strobes are plain copies (or the inverse) of the core clock, so the
//   memories are clocked in lock-step with the core.
//
// Ports:
//   clock        in   1   core clock, all state updates on the rising edge
//   reset        in   1   synchronous, active-high
//   imemaddr     out  32  byte address for the instruction ROM (next PC)
//   imemdataout  in   32  instruction word for the current PC
//   imemclk      out  1   ROM capture clock (= clock)
//   dmemaddr     out  32  data byte address (rs1 + immediate)
//   dmemdataout  in   32  load data, already aligned and extended externally
//   dmemdatain   out  32  store data (rs2, unshifted)
//   dmemrdclk    out  1   data read clock (= ~clock)
//   dmemwrclk    out  1   data write clock (= clock)
//   dmemop       out  3   access size/sign, taken straight from funct3
//   dmemwe       out  1   store enable
//   dbgdata      out  32  current PC
// ----------------------------------------------------------------------------
module rv32i_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemdataout,
    output logic        imemclk,
    output logic [31:0] dmemaddr,
    input  logic [31:0] dmemdataout,
    output logic [31:0] dmemdatain,
    output logic        dmemrdclk,
    output logic        dmemwrclk,
    output logic [2:0]  dmemop,
    output logic        dmemwe,
    output logic [31:0] dbgdata
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic [31:0] regs [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] jalr_sum;

    logic        rd_we;
    logic [31:0] rd_val;
    logic        branch_taken;
    logic        op_valid;
    logic        opimm_valid;

    // Shared integer ALU. 'alt' selects SUB for funct3=000 and SRA for 101.
    function automatic logic [31:0] alu(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [2:0]  f3,
                                        input logic        alt);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign instr   = imemdataout;
    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];

    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {instr[31:12], 12'b0};
    assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // x0 is hardwired to zero on the read side, so regs[0] is never observed.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign pc_plus4 = pc + 32'd4;
    assign jalr_sum = rs1_val + imm_i;

    // Encodings outside the defined funct7 patterns are treated as NOPs.
    always_comb begin
        opimm_valid = 1'b1;
        if (funct3 == 3'b001) begin
            opimm_valid = (funct7 == 7'h00);
        end else if (funct3 == 3'b101) begin
            opimm_valid = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
        op_valid = (funct7 == 7'h00) ||
                   ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end

    // Branch condition; funct3 values 010/011 are undefined and never taken.
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    // Main decode: register write-back value and the next PC. Anything not
    // recognised (FENCE, SYSTEM, unknown opcodes) falls through as a NOP.
    always_comb begin
        rd_we   = 1'b0;
        rd_val  = 32'd0;
        next_pc = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OPC_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            OPC_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = jalr_sum & ~32'd1;
            end
            OPC_BRANCH: begin
                if (branch_taken) begin
                    next_pc = pc + imm_b;
                end
            end
            OPC_LOAD: begin
                rd_we  = 1'b1;
                rd_val = dmemdataout;
            end
            OPC_OPIMM: begin
                rd_we  = opimm_valid;
                rd_val = alu(rs1_val, imm_i, funct3, (funct3 == 3'b101) && instr[30]);
            end
            OPC_OP: begin
                rd_we  = op_valid;
                rd_val = alu(rs1_val, rs2_val, funct3, instr[30]);
            end
            default: begin
                rd_we = 1'b0;
            end
        endcase
        // The ROM must be fetching the reset vector while reset is held.
        if (reset) begin
            next_pc = RESET_PC;
        end
    end

    // Program counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Register file write port; writes to x0 are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (rd_we && (rd != 5'd0)) begin
            regs[rd] <= rd_val;
        end
    end

    assign imemaddr   = next_pc;
    assign imemclk    = clock;
    assign dmemaddr   = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign dmemdatain = rs2_val;
    assign dmemrdclk  = ~clock;
    assign dmemwrclk  = clock;
    assign dmemop     = funct3;
    assign dmemwe     = (opcode == OPC_STORE) && !reset;
    assign dbgdata    = pc;

endmodule

// File: tb/tb_rv32i_core.sv
// ----------------------------------------------------------------------------
// tb_rv32i_core
//
// Self-checking bench for rv32i_core. The bench plays the role of both
// memories: it presents the instruction for the PC it expects and a load
// value every cycle. A directed program table covers reset, shifts, stores,
// byte load, branches and jumps; then a randomised instruction stream is
// checked against an instruction-level model of RV32I.
// ----------------------------------------------------------------------------
module tb_rv32i_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imemaddr;
    logic [31:0] imemdataout = 32'd0;
    logic        imemclk;
    logic [31:0] dmemaddr;
    logic [31:0] dmemdataout = 32'd0;
    logic [31:0] dmemdatain;
    logic        dmemrdclk;
    logic        dmemwrclk;
    logic [2:0]  dmemop;
    logic        dmemwe;
    logic [31:0] dbgdata;

    int checks   = 0;
    int failures = 0;

    // One cycle's worth of stimulus and the outputs it must produce.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] ld;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic        chk_addr;
        logic        chk_wdata;
    } vec_t;

    // Instruction-level reference state.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    rv32i_core dut (
        .clock       (clock),
        .reset       (reset),
        .imemaddr    (imemaddr),
        .imemdataout (imemdataout),
        .imemclk     (imemclk),
        .dmemaddr    (dmemaddr),
        .dmemdataout (dmemdataout),
        .dmemdatain  (dmemdatain),
        .dmemrdclk   (dmemrdclk),
        .dmemwrclk   (dmemwrclk),
        .dmemop      (dmemop),
        .dmemwe      (dmemwe),
        .dbgdata     (dbgdata)
    );

    always #5 clock = ~clock;

    // Instruction format encoders.
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[31:12], rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] ld,
                                input logic [31:0] pc, input logic [31:0] npc,
                                input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] op,
                                input logic chk_addr, input logic chk_wdata);
        vec_t v;
        v.instr = instr; v.ld = ld; v.pc = pc; v.npc = npc; v.we = we;
        v.addr = addr; v.wdata = wdata; v.op = op;
        v.chk_addr = chk_addr; v.chk_wdata = chk_wdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Drive one instruction right after the rising edge, check the outputs
    // mid-cycle, then advance to just after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        imemdataout = v.instr;
        dmemdataout = v.ld;
        #2;
        checkOutput("dbgdata_pc", dbgdata, v.pc);
        checkOutput("imemaddr_nextpc", imemaddr, v.npc);
        checkOutput("dmemwe", {31'b0, dmemwe}, {31'b0, v.we});
        checkOutput("dmemop", {29'b0, dmemop}, {29'b0, v.op});
        if (v.chk_addr) checkOutput("dmemaddr", dmemaddr, v.addr);
        if (v.chk_wdata) checkOutput("dmemdatain", dmemdatain, v.wdata);
        @(posedge clock);
        #1;
    endtask

    // Architectural model: executes one instruction on m_regs/m_pc and
    // returns what the core's outputs must show during that cycle.
    task automatic model_step(input logic [31:0] ins, input logic [31:0] ld, output vec_t v);
        logic [31:0] a, b, ii, is, ib, res;
        logic [4:0]  sh;
        logic [2:0]  f3;
        logic        wr;
        a   = (ins[19:15] == 0) ? 32'd0 : m_regs[ins[19:15]];
        b   = (ins[24:20] == 0) ? 32'd0 : m_regs[ins[24:20]];
        ii  = 32'($signed(ins[31:20]));
        is  = 32'($signed({ins[31:25], ins[11:7]}));
        ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        f3  = ins[14:12];
        sh  = ins[24:20];
        wr  = 1'b0;
        res = 32'd0;
        v = mk(ins, ld, m_pc, m_pc + 4, 1'b0, 32'd0, 32'd0, f3, 1'b0, 1'b0);
        case (ins[6:0])
            7'h37: begin wr = 1; res = {ins[31:12], 12'h000}; end
            7'h17: begin wr = 1; res = m_pc + {ins[31:12], 12'h000}; end
            7'h6F: begin
                wr = 1; res = m_pc + 4;
                v.npc = m_pc + 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67: begin
                wr = 1; res = m_pc + 4;
                v.npc = (a + ii) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                logic t;
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = ($signed(a) < $signed(b));
                    3'd5: t = !($signed(a) < $signed(b));
                    3'd6: t = (a < b);
                    3'd7: t = !(a < b);
                    default: t = 1'b0;
                endcase
                if (t) v.npc = m_pc + ib;
            end
            7'h03: begin wr = 1; res = ld; v.chk_addr = 1; v.addr = a + ii; end
            7'h23: begin
                v.we = 1; v.chk_addr = 1; v.chk_wdata = 1;
                v.addr = a + is; v.wdata = b;
            end
            7'h13, 7'h33: begin
                logic [31:0] y;
                y  = (ins[6:0] == 7'h13) ? ii : b;
                wr = 1;
                case (f3)
                    3'd0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - y : a + y;
                    3'd1: res = a << y[4:0];
                    3'd2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < y) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ y;
                    3'd5: res = ins[30] ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
                    3'd6: res = a | y;
                    default: res = a & y;
                endcase
            end
            default: wr = 1'b0;
        endcase
        if (sh == 5'd31 && 1'b0) wr = 1'b0;
        if (wr && ins[11:7] != 0) m_regs[ins[11:7]] = res;
        m_pc = v.npc;
    endtask

    // Random legal instruction from every RV32I class plus NOP-class encodings.
    function automatic logic [31:0] gen_random_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] r;
        int          k;
        k   = $urandom_range(0, 11);
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        r   = $urandom;
        case (k)
            0: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00,
                            rs2, rs1, f3, rd, 7'h33);
            1, 2: begin
                if (f3 == 3'd1) r = {20'b0, 7'h00, r[4:0]};
                else if (f3 == 3'd5) r = {20'b0, r[5] ? 7'h20 : 7'h00, r[4:0]};
                return enc_i(r, rs1, f3, rd, 7'h13);
            end
            3: return enc_u(r, rd, 7'h37);
            4: return enc_u(r, rd, 7'h17);
            5: return enc_j(r, rd);
            6: return enc_i(r, rs1, 3'd0, rd, 7'h67);
            7: begin
                f3 = 3'($urandom_range(0, 5));
                if (f3 >= 3'd2) f3 = f3 + 3'd2;
                return enc_b(r, rs2, rs1, f3);
            end
            8: begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 >= 3'd3) f3 = f3 + 3'd1;
                return enc_i(r, rs1, f3, rd, 7'h03);
            end
            9, 10: return enc_s(r, rs2, rs1, 3'($urandom_range(0, 2)));
            default: begin
                case (r[1:0])
                    2'd0: return {r[31:7], 7'b0001111};
                    2'd1: return 32'h0000_0073;
                    2'd2: return 32'h0010_0073;
                    default: return {r[31:7], 7'b1111111};
                endcase
            end
        endcase
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [31:0] sw_probe;

        // Directed program: x1=-1, x2=0xF, x3=-1, x5=0x00100000, x6=0xAB.
        tbl.push_back(mk(enc_i(32'hFFFF_FFFF, 5'd0, 3'd0, 5'd1, 7'h13), 0, 32'h00, 32'h04, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(enc_i(32'd28, 5'd1, 3'd5, 5'd2, 7'h13),         0, 32'h04, 32'h08, 0, 0, 0, 3'd5, 0, 0));
        tbl.push_back(mk(enc_i(32'h41C, 5'd1, 3'd5, 5'd3, 7'h13),        0, 32'h08, 32'h0C, 0, 0, 0, 3'd5, 0, 0));
        tbl.push_back(mk(enc_u(32'h0010_0000, 5'd5, 7'h37),              0, 32'h0C, 32'h10, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(enc_s(32'd8, 5'd2, 5'd5, 3'd2),                 0, 32'h10, 32'h14, 1, 32'h0010_0008, 32'h0000_000F, 3'd2, 1, 1));
        tbl.push_back(mk(enc_i(32'd3, 5'd5, 3'd4, 5'd6, 7'h03), 32'h0000_00AB, 32'h14, 32'h18, 0, 32'h0010_0003, 0, 3'd4, 1, 0));
        tbl.push_back(mk(enc_b(32'd8, 5'd0, 5'd1, 3'd4),                 0, 32'h18, 32'h20, 0, 0, 0, 3'd4, 0, 0));
        tbl.push_back(mk(enc_j(32'd16, 5'd1),                            0, 32'h20, 32'h30, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(enc_s(32'd0, 5'd6, 5'd0, 3'd2),                 0, 32'h30, 32'h34, 1, 32'h0, 32'h0000_00AB, 3'd2, 1, 1));
        tbl.push_back(mk(enc_s(32'd4, 5'd1, 5'd0, 3'd2),                 0, 32'h34, 32'h38, 1, 32'h4, 32'h0000_0024, 3'd2, 1, 1));
        tbl.push_back(mk(enc_b(32'd8, 5'd0, 5'd3, 3'd6),                 0, 32'h38, 32'h3C, 0, 0, 0, 3'd6, 0, 0));
        tbl.push_back(mk(enc_s(32'd8, 5'd3, 5'd0, 3'd2),                 0, 32'h3C, 32'h40, 1, 32'h8, 32'hFFFF_FFFF, 3'd2, 1, 1));
        tbl.push_back(mk(enc_i(32'd1, 5'd1, 3'd0, 5'd0, 7'h67),          0, 32'h40, 32'h24, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(enc_s(32'd12, 5'd2, 5'd0, 3'd2),                0, 32'h24, 32'h28, 1, 32'hC, 32'h0000_000F, 3'd2, 1, 1));
        tbl.push_back(mk(enc_s(32'd16, 5'd5, 5'd0, 3'd2),                0, 32'h28, 32'h2C, 1, 32'h10, 32'h0010_0000, 3'd2, 1, 1));
        tbl.push_back(mk(enc_i(32'd5, 5'd0, 3'd0, 5'd0, 7'h13),          0, 32'h2C, 32'h30, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(enc_s(32'd20, 5'd0, 5'd0, 3'd2),                0, 32'h30, 32'h34, 1, 32'h14, 32'h0, 3'd2, 1, 1));

        // Reset held for three cycles with a store on the instruction bus.
        sw_probe    = enc_s(32'd0, 5'd2, 5'd0, 3'd2);
        imemdataout = sw_probe;
        repeat (3) begin
            @(posedge clock);
            #1;
            checkOutput("reset_dbgdata", dbgdata, 32'h0);
            checkOutput("reset_imemaddr", imemaddr, 32'h0);
            checkOutput("reset_dmemwe", {31'b0, dmemwe}, 32'd0);
            checkOutput("imemclk", {31'b0, imemclk}, 32'd1);
            checkOutput("dmemrdclk", {31'b0, dmemrdclk}, 32'd0);
            checkOutput("dmemwrclk", {31'b0, dmemwrclk}, 32'd1);
        end
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
        end

        // Reset asserted mid-program: fetch redirects at once, PC follows at the edge.
        reset       = 1'b1;
        imemdataout = sw_probe;
        #2;
        checkOutput("midreset_imemaddr", imemaddr, 32'h0);
        checkOutput("midreset_dmemwe", {31'b0, dmemwe}, 32'd0);
        checkOutput("midreset_pc_before", dbgdata, 32'h34);
        @(posedge clock);
        #1;
        checkOutput("midreset_pc_after", dbgdata, 32'h0);
        reset = 1'b0;

        // Randomised stream from the clean post-reset state.
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            model_step(gen_random_instr(), $urandom, v);
            applyStimulus(v);
        end

        // Expose every register through a store.
        for (int r = 0; r < 32; r++) begin
            model_step(enc_s(32'd0, 5'(r), 5'd0, 3'd2), $urandom, v);
            applyStimulus(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
